alu_result_stage: RTL and testbench
===================================

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 Parameter: WIDTH, 32, datapath width of the result captured from the 8:1 result multiplexer.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  upstream result valid.
REQ-005 in_ready  output  1  stage can accept a result this cycle.
REQ-006 in_op  input  3  select code that drove the result mux (S2,S1,S0).
REQ-007 in_result  input  WIDTH  mux output.
REQ-008 in_carry  input  1  adder carry-out.
REQ-009 in_ovf  input  1  adder signed overflow.
REQ-010 out_valid  output  1  registered result available.
REQ-011 out_ready  input  1  downstream (writeback) accepts.
REQ-012 out_op  output  3  op code of the presented result.
REQ-013 out_result  output  WIDTH  registered result.
REQ-014 out_flags  output  4  {N,Z,C,V} for the presented result.
REQ-015 out_count  output  16  number of completed output handshakes.

Function
REQ-016 Input transfer SHALL occur when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-017 Storage SHALL be a main register plus one skid register; latency in_valid-accept to out_valid SHALL be exactly 1 cycle when empty.
REQ-018 in_ready SHALL be a registered signal equal to NOT(skid occupied).
REQ-019 Transfer into an empty main, or into main while main drains the same cycle, SHALL write main.
REQ-020 Transfer while main is held (out_valid && !out_ready) SHALL write skid; in_ready SHALL be 0 the next cycle.
REQ-021 When main drains and skid is occupied, skid SHALL move to main that cycle and in_ready SHALL return to 1 the next cycle.
REQ-022 Results SHALL leave in acceptance order; no result SHALL be dropped or duplicated.
REQ-023 out_valid SHALL be 1 exactly when main is occupied; out_op/out_result/out_flags SHALL hold stable while out_valid && !out_ready.
REQ-024 Flags SHALL be computed at capture: N = in_result[WIDTH-1]; Z = (in_result == 0).
REQ-025 C and V SHALL equal in_carry and in_ovf for op ADD (3'd0) and SUB (3'd1); for all other ops C = 0 and V = 0.
REQ-026 out_count SHALL increment by 1 on each output transfer and wrap 16'hFFFF -> 16'h0000.
REQ-027 in_* inputs SHALL be ignored when no input transfer occurs.

Reset
REQ-028 On rst asserted, asynchronously: main and skid empty, out_valid = 0, in_ready = 1, out_op = 0, out_result = 0, out_flags = 0, out_count = 0.
REQ-029 rst mid-operation SHALL discard both held results; no output transfer SHALL be reported for them.
REQ-030 First input transfer SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-031 Package alu_pkg SHALL hold the 3-bit op encodings (ALU_ADD = 0, ALU_SUB = 1, others), flag bit indices (N = 3, Z = 2, C = 1, V = 0), and the WIDTH default.
REQ-032 Flag generation SHALL be one combinational sub-module, alu_flag_gen, instantiated once on the input path.

Verification
REQ-033 Reset then single ADD: in_result = 32'h0000_0000, in_carry = 1, in_ovf = 0, out_ready = 1 -> next cycle out_valid = 1, out_flags = 4'b0110, out_count = 1 after the handshake.
REQ-034 Backpressure: out_ready = 0, two back-to-back results A = 32'h8000_0001 (op 2), B = 32'h5 (op 0, carry = 1) -> in_ready = 0 after B; A is presented with flags 4'b1000; raise out_ready -> A then B (flags 4'b0010), in_ready = 1.
REQ-035 Non-arithmetic op 3'd5 with in_carry = 1, in_ovf = 1 -> out_flags C = 0, V = 0.
REQ-036 Streaming: in_valid and out_ready held 1 for 20 cycles with incrementing data -> one result per cycle, in order, in_ready never 0.
REQ-037 Wrap: preload 65535 handshakes -> out_count = 16'hFFFF, one more -> 16'h0000.
REQ-038 rst pulse while both entries are full -> out_valid = 0 and in_ready = 1 immediately, out_count = 0, held results never appear.

Source files
------------

// File: rtl/alu_pkg.sv
// ALU result stage shared definitions: op encodings, flag bit
// positions, default datapath width and the arithmetic-op helper.
package alu_pkg;
  localparam int ALU_WIDTH = 32;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLT = 3'd5,
    ALU_SLL = 3'd6,
    ALU_SRL = 3'd7
  } alu_op_e;

  function automatic logic is_arith(
    input logic [2:0] op
  );
    return (op == ALU_ADD) ||
           (op == ALU_SUB);
  endfunction
endpackage

// File: rtl/alu_result_stage_if.sv
// Handshake bundle between the ALU result mux, the result stage and
// writeback. slave = stage side, master = producer/consumer side.
interface alu_result_stage_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_result;
  logic             in_carry;
  logic             in_ovf;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       out_op;
  logic [WIDTH-1:0] out_result;
  logic [3:0]       out_flags;
  logic [15:0]      out_count;

  modport slave (
    input  in_valid, in_op, in_result,
    input  in_carry, in_ovf, out_ready,
    output in_ready, out_valid, out_op,
    output out_result, out_flags, out_count
  );

  modport master (
    output in_valid, in_op, in_result,
    output in_carry, in_ovf, out_ready,
    input  in_ready, out_valid, out_op,
    input  out_result, out_flags, out_count
  );
endinterface

// File: rtl/alu_flag_gen.sv
// Combinational {N,Z,C,V} generation for a mux result.
// Ports: i_op, i_result, i_carry, i_ovf in; o_flags out.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_result,
  input  logic             i_carry,
  input  logic             i_ovf,
  output logic [3:0]       o_flags
);
  always_comb begin
    o_flags = '0;
    o_flags[FLAG_N] = i_result[WIDTH-1];
    o_flags[FLAG_Z] = (i_result == '0);
    // carry/overflow only mean something for the adder
    if (is_arith(i_op)) begin
      o_flags[FLAG_C] = i_carry;
      o_flags[FLAG_V] = i_ovf;
    end
  end
endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: main + skid buffer, flags at capture,
// handshake counter. Ports: clk, rst, bus (alu_result_stage_if.slave).
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  alu_result_stage_if.slave bus
);
  logic             r_main_vld;
  logic [2:0]       r_main_op;
  logic [WIDTH-1:0] r_main_res;
  logic [3:0]       r_main_fl;
  logic             r_skid_vld;
  logic [2:0]       r_skid_op;
  logic [WIDTH-1:0] r_skid_res;
  logic [3:0]       r_skid_fl;
  logic             r_in_ready;
  logic [15:0]      r_count;

  logic [3:0] w_flags;
  logic       w_in_xfer;
  logic       w_out_xfer;
  logic       w_skid_nxt;

  alu_flag_gen #(
    .WIDTH (WIDTH)
  ) u_flag_gen (
    .i_op     (bus.in_op),
    .i_result (bus.in_result),
    .i_carry  (bus.in_carry),
    .i_ovf    (bus.in_ovf),
    .o_flags  (w_flags)
  );

  assign w_in_xfer  = bus.in_valid & r_in_ready;
  assign w_out_xfer = r_main_vld & bus.out_ready;

  // skid fills only when main is held; drains whenever main drains
  always_comb begin
    w_skid_nxt = r_skid_vld;
    if (w_out_xfer)
      w_skid_nxt = 1'b0;
    else if (w_in_xfer && r_main_vld)
      w_skid_nxt = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_vld <= 1'b0;
      r_main_op  <= '0;
      r_main_res <= '0;
      r_main_fl  <= '0;
      r_skid_vld <= 1'b0;
      r_skid_op  <= '0;
      r_skid_res <= '0;
      r_skid_fl  <= '0;
      r_in_ready <= 1'b1;
      r_count    <= '0;
    end else begin
      r_skid_vld <= w_skid_nxt;
      r_in_ready <= ~w_skid_nxt;
      if (w_out_xfer) begin
        r_count <= r_count + 16'd1;
        if (r_skid_vld) begin
          r_main_op  <= r_skid_op;
          r_main_res <= r_skid_res;
          r_main_fl  <= r_skid_fl;
        end else begin
          r_main_vld <= w_in_xfer;
          if (w_in_xfer) begin
            r_main_op  <= bus.in_op;
            r_main_res <= bus.in_result;
            r_main_fl  <= w_flags;
          end
        end
      end else if (w_in_xfer) begin
        if (!r_main_vld) begin
          r_main_vld <= 1'b1;
          r_main_op  <= bus.in_op;
          r_main_res <= bus.in_result;
          r_main_fl  <= w_flags;
        end else begin
          r_skid_op  <= bus.in_op;
          r_skid_res <= bus.in_result;
          r_skid_fl  <= w_flags;
        end
      end
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.out_valid  = r_main_vld;
  assign bus.out_op     = r_main_op;
  assign bus.out_result = r_main_res;
  assign bus.out_flags  = r_main_fl;
  assign bus.out_count  = r_count;
endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed cases plus
// randomized traffic against a queue-based reference model.
module tb_alu_result_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;

  alu_result_stage_if #(.WIDTH(32)) ifc ();

  alu_result_stage #(
    .WIDTH (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] res;
    logic [3:0]  fl;
  } ent_t;

  ent_t        q[$];
  logic [15:0] m_count;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] exp_flags(
    input logic [2:0]  op,
    input logic [31:0] r,
    input logic        c,
    input logic        o
  );
    logic ar;
    ar = (op == 3'd0) || (op == 3'd1);
    return {r[31], r == 32'd0, ar & c, ar & o};
  endfunction

  task automatic check_all();
    chk("in_ready", ifc.in_ready, q.size() < 2);
    chk("out_valid", ifc.out_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("out_op", ifc.out_op, q[0].op);
      chk("out_result", ifc.out_result, q[0].res);
      chk("out_flags", ifc.out_flags, q[0].fl);
    end
    chk("out_count", ifc.out_count, m_count);
  endtask

  // called at a negedge; returns at the next negedge after checking
  task automatic step(
    input logic        v,
    input logic [2:0]  op,
    input logic [31:0] r,
    input logic        c,
    input logic        o,
    input logic        ordy
  );
    logic ix, ox;
    ent_t e;
    ifc.in_valid  = v;
    ifc.in_op     = op;
    ifc.in_result = r;
    ifc.in_carry  = c;
    ifc.in_ovf    = o;
    ifc.out_ready = ordy;
    ix = v && (q.size() < 2);
    ox = (q.size() > 0) && ordy;
    @(posedge clk);
    if (ox) begin
      void'(q.pop_front());
      m_count = m_count + 16'd1;
    end
    if (ix) begin
      e.op  = op;
      e.res = r;
      e.fl  = exp_flags(op, r, c, o);
      q.push_back(e);
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    q.delete();
    m_count = '0;
    rst = 1'b0;
  endtask

  initial begin
    int n;
    ifc.in_valid  = 1'b0;
    ifc.in_op     = '0;
    ifc.in_result = '0;
    ifc.in_carry  = 1'b0;
    ifc.in_ovf    = 1'b0;
    ifc.out_ready = 1'b0;
    m_count = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", ifc.out_valid, 0);
    chk("rst_in_ready", ifc.in_ready, 1);
    chk("rst_out_op", ifc.out_op, 0);
    chk("rst_out_result", ifc.out_result, 0);
    chk("rst_out_flags", ifc.out_flags, 0);
    chk("rst_out_count", ifc.out_count, 0);
    rst = 1'b0;

    // single ADD of zero with carry
    step(1, 3'd0, 32'h0, 1, 0, 1);
    chk("add_valid", ifc.out_valid, 1);
    chk("add_flags", ifc.out_flags, 4'b0110);
    step(0, 3'd0, 32'h0, 0, 0, 1);
    chk("add_count", ifc.out_count, 16'd1);

    // backpressure into skid
    step(1, 3'd2, 32'h8000_0001, 0, 0, 0);
    step(1, 3'd0, 32'h5, 1, 0, 0);
    chk("bp_in_ready", ifc.in_ready, 0);
    chk("bp_a_res", ifc.out_result, 32'h8000_0001);
    chk("bp_a_flags", ifc.out_flags, 4'b1000);
    step(0, 3'd0, 32'h0, 0, 0, 1);
    chk("bp_b_res", ifc.out_result, 32'h5);
    chk("bp_b_flags", ifc.out_flags, 4'b0010);
    chk("bp_ready_back", ifc.in_ready, 1);
    step(0, 3'd0, 32'h0, 0, 0, 1);

    // non-arithmetic op masks carry/overflow
    step(1, 3'd5, 32'h1234, 1, 1, 1);
    chk("op5_cv", ifc.out_flags[1:0], 2'b00);
    step(0, 3'd0, 32'h0, 0, 0, 1);

    // streaming
    for (int i = 0; i < 20; i++) begin
      step(1, 3'(i), 32'(100 + i), 1, 1, 1);
      chk("stream_ready", ifc.in_ready, 1);
    end

    // randomized traffic
    for (int i = 0; i < 2000; i++)
      step(1'($urandom_range(0, 3) != 0),
           3'($urandom), 32'($urandom) & (($urandom_range(0, 7) == 0) ? 32'h0 : 32'hFFFF_FFFF),
           1'($urandom), 1'($urandom),
           1'($urandom_range(0, 2) != 0));

    // reset while main and skid are both full
    step(1, 3'd3, 32'hAAAA_0001, 0, 0, 0);
    step(1, 3'd4, 32'hAAAA_0002, 0, 0, 0);
    step(0, 3'd0, 32'h0, 0, 0, 0);
    chk("full_in_ready", ifc.in_ready, 0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", ifc.out_valid, 0);
    chk("mid_rst_ready", ifc.in_ready, 1);
    chk("mid_rst_count", ifc.out_count, 0);
    q.delete();
    m_count = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++)
      step(0, 3'd0, 32'h0, 0, 0, 1);
    step(1, 3'd1, 32'h77, 0, 1, 1);
    chk("post_rst_res", ifc.out_result, 32'h77);

    // counter wrap
    do_reset();
    n = 0;
    while (m_count != 16'hFFFF && n < 70000) begin
      step(1, 3'd0, 32'(n), 0, 0, 1);
      n++;
    end
    chk("wrap_ffff", ifc.out_count, 16'hFFFF);
    step(1, 3'd0, 32'h1, 0, 0, 1);
    chk("wrap_zero", ifc.out_count, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
